ifu_decd: RTL and testbench

- Instruction-fetch and pre-decode unit for the multicycle MIPS32 core.
- Sits between instruction memory and the multicycle controller:
  - owns the PC;
  - fetches over a req/ack handshake;
  - latches the instruction register (IR);
  - produces the 7-bit decoded-op code and register/immediate fields the controller and datapath consume.
- Also the receiving end of the controller's next-PC command (adv pulse + nPCOp + zero).

---
 rtl/ifu_decd_pkg.sv | 38 +++
 rtl/ifu_decd_if.sv | 23 ++
 rtl/ifu_decd_npc_calc.sv | 33 +++
 rtl/ifu_decd.sv | 103 ++++++++++
 tb/tb_ifu_decd.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_decd_pkg.sv
// Shared types and codes for the instruction-fetch/pre-decode unit and the controller.
// No logic, no latency.
// No backpressure: this package holds constants and helpers only.
package ifu_decd_pkg;

    // Next-PC command codes issued by the controller with pc_adv.
    typedef enum logic [1:0] {
        NPC_NML = 2'b00,
        NPC_BEQ = 2'b01,
        NPC_J   = 2'b10,
        NPC_RSV = 2'b11
    } npc_op_e;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_FETCH = 2'b01,
        S_VALID = 2'b10
    } ifu_state_e;

    // Decoded-op codes: R-type is {funct,1}, everything else is {opcode,0}.
    localparam logic [6:0] OP_ADDU = 7'b1000011;
    localparam logic [6:0] OP_SUBU = 7'b1000111;
    localparam logic [6:0] OP_ORI  = 7'b0011010;
    localparam logic [6:0] OP_LW   = 7'b1000110;
    localparam logic [6:0] OP_SW   = 7'b1010110;
    localparam logic [6:0] OP_BEQ  = 7'b0001000;
    localparam logic [6:0] OP_J    = 7'b0000100;

    // Fold opcode/funct into the 7-bit op code; the LSB tags R-type.
    function automatic logic [6:0] decd_op(input logic [31:0] ir);
        if (ir[31:26] == 6'b000000) begin
            return {ir[5:0], 1'b1};
        end
        return {ir[31:26], 1'b0};
    endfunction

endpackage

// File: rtl/ifu_decd_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and memory (slave).
// Request is held until ack; completion may come in the first request cycle.
// Backpressure: memory stalls the fetch simply by withholding imem_ack.
interface ifu_decd_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/ifu_decd_npc_calc.sv
// Combinational next-PC: sequential, taken/not-taken beq, or 26-bit jump.
// Zero latency; the result is only consumed on the pc_adv edge.
// No backpressure: pure function of its inputs.
module ifu_decd_npc_calc
    import ifu_decd_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  npc_op_i,
    input  logic        zero_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] imm26_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] npc_o
);

    logic [31:0] br_off;

    assign pc_plus4_o = pc_i + 32'd4;
    assign br_off     = {{14{imm16_i[15]}}, imm16_i, 2'b00};

    // Select the next PC; the reserved code falls back to sequential.
    always_comb begin
        npc_o = pc_plus4_o;
        case (npc_op_e'(npc_op_i))
            NPC_NML: npc_o = pc_plus4_o;
            NPC_BEQ: npc_o = zero_i ? (pc_plus4_o + br_off) : pc_plus4_o;
            NPC_J:   npc_o = {pc_plus4_o[31:28], imm26_i, 2'b00};
            NPC_RSV: npc_o = pc_plus4_o;
            default: npc_o = pc_plus4_o;
        endcase
    end

endmodule

// File: rtl/ifu_decd.sv
// Fetch/pre-decode: owns PC and IR, fetches over req/ack, exposes decoded fields.
// Latency: ir_valid two edges after clr release with zero-wait memory; PC updates on the pc_adv edge.
// Backpressure: req held (addr stable) until ack; pc_adv only honoured once IR is valid.
module ifu_decd
    import ifu_decd_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              clr,
    ifu_decd_if.master        imem,
    input  logic              pc_adv,
    input  logic [1:0]        nPCOp,
    input  logic              zero,
    output logic              ir_valid,
    output logic [6:0]        decdOp,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm16,
    output logic [25:0]       imm26,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       instr_cnt
);

    ifu_state_e  state_q;
    logic        req_q;
    logic        ir_valid_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_w;

    assign cnt_d = cnt_q + 32'd1;

    ifu_decd_npc_calc u_npc (
        .pc_i       (pc_q),
        .npc_op_i   (nPCOp),
        .zero_i     (zero),
        .imm16_i    (ir_q[15:0]),
        .imm26_i    (ir_q[25:0]),
        .pc_plus4_o (pc_plus4_w),
        .npc_o      (pc_d)
    );

    // Fetch FSM with registered req/valid; clr overrides everything, including a same-cycle ack.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_INIT;
            req_q      <= 1'b0;
            ir_valid_q <= 1'b0;
            pc_q       <= RESET_PC;
            ir_q       <= 32'd0;
            cnt_q      <= 32'd0;
        end else begin
            case (state_q)
                S_INIT: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        ir_q       <= imem.imem_rdata;
                        ir_valid_q <= 1'b1;
                        req_q      <= 1'b0;
                        state_q    <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (pc_adv) begin
                        pc_q       <= pc_d;
                        cnt_q      <= cnt_d;
                        ir_valid_q <= 1'b0;
                        req_q      <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;

    assign ir_valid  = ir_valid_q;
    assign decdOp    = decd_op(ir_q);
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign imm16     = ir_q[15:0];
    assign imm26     = ir_q[25:0];
    assign pc        = pc_q;
    assign pc_plus4  = pc_plus4_w;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_ifu_decd.sv
// Bench for ifu_decd: table of fetch/retire steps plus hand sequences for stalls and reset.
// Scoreboard queues carry expected fetch addresses and expected IR words.
// Outputs sampled on the falling edge; inputs driven right after it.
module tb_ifu_decd;
    import ifu_decd_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        pc_adv;
    logic [1:0]  nPCOp;
    logic        zero;
    logic        ir_valid;
    logic [6:0]  decdOp;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] pc, pc_plus4, instr_cnt;

    ifu_decd_if imem ();

    ifu_decd #(.RESET_PC(32'h0000_3000)) dut (
        .clk       (clk),
        .clr       (clr),
        .imem      (imem.master),
        .pc_adv    (pc_adv),
        .nPCOp     (nPCOp),
        .zero      (zero),
        .ir_valid  (ir_valid),
        .decdOp    (decdOp),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm16     (imm16),
        .imm26     (imm26),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          dly;
        logic [1:0]  op;
        logic        z;
        logic [6:0]  edecd;
        logic [31:0] enpc;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic [6:0]  decd;
    } dec_t;

    vec_t        tbl [10];
    logic [31:0] addr_q [$];
    dec_t        dec_q [$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Wait (bounded) until imem_req is high at a falling edge; n counts edges waited.
    task automatic wait_req(output int n);
        n = 0;
        while (imem.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem.imem_req !== 1'b1) chk("req_timeout", 32'(imem.imem_req), 32'd1);
    endtask

    // Complete the current fetch with a word and check what the DUT latched.
    task automatic do_ack(input logic [31:0] word, input logic [6:0] edecd);
        dec_t e;
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = word;
        dec_q.push_back('{word: word, decd: edecd});
        @(negedge clk);
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = $urandom;
        e = dec_q.pop_front();
        chk("ir_valid_set", 32'(ir_valid), 32'd1);
        chk("req_drop",     32'(imem.imem_req), 32'd0);
        chk("decdOp",       32'(decdOp), 32'(e.decd));
        chk("rs",           32'(rs), 32'(e.word[25:21]));
        chk("rt",           32'(rt), 32'(e.word[20:16]));
        chk("rd",           32'(rd), 32'(e.word[15:11]));
        chk("imm16",        32'(imm16), 32'(e.word[15:0]));
        chk("imm26",        32'(imm26), 32'(e.word[25:0]));
    endtask

    // Retire the current instruction and check the new PC and count.
    task automatic do_adv(input logic [1:0] op, input logic z, input logic [31:0] enpc);
        pc_adv = 1'b1;
        nPCOp  = op;
        zero   = z;
        addr_q.push_back(enpc);
        @(negedge clk);
        pc_adv = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        chk("instr_cnt",   instr_cnt, exp_cnt);
        chk("pc_next",     pc, enpc);
        chk("pc_plus4",    pc_plus4, enpc + 32'd4);
        chk("ir_valid_clr", 32'(ir_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a;

        tbl[0] = '{32'h0022_1821, 0, 2'b00, 1'b0, OP_ADDU, 32'h0000_3004};
        tbl[1] = '{32'h1022_FFFF, 3, 2'b01, 1'b1, OP_BEQ,  32'h0000_3004};
        tbl[2] = '{32'h1022_FFFF, 0, 2'b01, 1'b0, OP_BEQ,  32'h0000_3008};
        tbl[3] = '{32'h0800_0C10, 1, 2'b10, 1'b0, OP_J,    32'h0000_3040};
        tbl[4] = '{32'h0800_0C01, 0, 2'b10, 1'b1, OP_J,    32'h0000_3004};
        tbl[5] = '{32'h1022_0002, 0, 2'b01, 1'b1, OP_BEQ,  32'h0000_3010};
        tbl[6] = '{32'h3485_1234, 2, 2'b11, 1'b1, OP_ORI,  32'h0000_3014};
        tbl[7] = '{32'h0022_1823, 0, 2'b00, 1'b1, OP_SUBU, 32'h0000_3018};
        tbl[8] = '{32'h8C22_0004, 0, 2'b00, 1'b0, OP_LW,   32'h0000_301C};
        tbl[9] = '{32'hAC22_0004, 0, 2'b00, 1'b0, OP_SW,   32'h0000_3020};

        clr = 1'b1;
        pc_adv = 1'b0;
        nPCOp = 2'b00;
        zero = 1'b0;
        imem.imem_ack = 1'b0;
        imem.imem_rdata = 32'd0;
        exp_cnt = 32'd0;
        repeat (2) @(negedge clk);

        chk("rst_req",      32'(imem.imem_req), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_pc",       pc, 32'h0000_3000);
        chk("rst_pc_plus4", pc_plus4, 32'h0000_3004);
        chk("rst_cnt",      instr_cnt, 32'd0);
        chk("rst_decdOp",   32'(decdOp), 32'b0000001);

        clr = 1'b0;
        addr_q.push_back(32'h0000_3000);

        for (int i = 0; i < 10; i++) begin
            wait_req(n);
            chk("req_latency", 32'(n), (i == 0) ? 32'd1 : 32'd0);
            a = addr_q.pop_front();
            chk("fetch_addr", imem.imem_addr, a);
            for (int d = 0; d < tbl[i].dly; d++) begin
                @(negedge clk);
                chk("stall_req",      32'(imem.imem_req), 32'd1);
                chk("stall_addr",     imem.imem_addr, a);
                chk("stall_ir_valid", 32'(ir_valid), 32'd0);
            end
            do_ack(tbl[i].rdata, tbl[i].edecd);
            do_adv(tbl[i].op, tbl[i].z, tbl[i].enpc);
        end

        // pc_adv while still fetching must be ignored.
        wait_req(n);
        a = addr_q.pop_front();
        chk("rob_addr", imem.imem_addr, a);
        pc_adv = 1'b1;
        nPCOp = 2'b10;
        @(negedge clk);
        pc_adv = 1'b0;
        chk("rob_fetch_pc",  pc, 32'h0000_3020);
        chk("rob_fetch_cnt", instr_cnt, exp_cnt);
        chk("rob_fetch_req", 32'(imem.imem_req), 32'd1);
        do_ack(32'h0022_1821, OP_ADDU);

        // ack while IR is already valid must be ignored.
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'h0800_0C10;
        @(negedge clk);
        imem.imem_ack = 1'b0;
        chk("rob_valid_decd", 32'(decdOp), 32'(OP_ADDU));
        chk("rob_valid_rd",   32'(rd), 32'd3);
        chk("rob_valid_vld",  32'(ir_valid), 32'd1);
        chk("rob_valid_pc",   pc, 32'h0000_3020);
        chk("rob_valid_cnt",  instr_cnt, exp_cnt);
        do_adv(2'b00, 1'b0, 32'h0000_3024);

        // clr in the middle of a fetch, with a simultaneous ack.
        wait_req(n);
        a = addr_q.pop_front();
        chk("clr_pre_addr", imem.imem_addr, a);
        clr = 1'b1;
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'h8C22_0004;
        @(negedge clk);
        clr = 1'b0;
        imem.imem_ack = 1'b0;
        exp_cnt = 32'd0;
        chk("clr_ir_valid", 32'(ir_valid), 32'd0);
        chk("clr_decdOp",   32'(decdOp), 32'b0000001);
        chk("clr_pc",       pc, 32'h0000_3000);
        chk("clr_cnt",      instr_cnt, 32'd0);
        chk("clr_req",      32'(imem.imem_req), 32'd0);
        wait_req(n);
        chk("clr_restart_lat",  32'(n), 32'd1);
        chk("clr_restart_addr", imem.imem_addr, 32'h0000_3000);
        do_ack(32'h0022_1821, OP_ADDU);
        do_adv(2'b00, 1'b0, 32'h0000_3004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
